// File: rtl/audio_gain_mixer_pkg.sv
// rtl/audio_gain_mixer_pkg.sv - shared types, key indices and helpers for the audio gain mixer
package mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int KEY_UP = 0;
  localparam int KEY_DN = 1;
  localparam int KEY_CH = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Active-low segments, bit0 = seg a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] on;
    case (nib)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      default: on = 7'h71;
    endcase
    return ~on;
  endfunction

endpackage

// File: rtl/audio_gain_mixer_if.sv
// rtl/audio_gain_mixer_if.sv - frame-in / sample-out stream interface of the mixer core
interface audio_gain_mixer_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 24
);
  logic [NUM_CH*SAMPLE_W-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [SAMPLE_W-1:0]        out_data;
  logic                       out_valid;
  logic                       out_ready;

  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/audio_gain_mixer_key_debounce.sv
// rtl/audio_gain_mixer_key_debounce.sv - active-low key synchroniser, debouncer and press pulse
module key_debounce
  import mixer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2, r_stable, r_press;
  logic [CNT_W-1:0] r_cnt;

  // A new level must differ from the accepted one for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

// File: rtl/audio_gain_mixer.sv
// rtl/audio_gain_mixer.sv - N-channel gain mixer: key-set gains, serial MAC, saturated mono output
module audio_gain_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int SAMPLE_W        = 24,
  parameter int GAIN_W          = 4,
  parameter int GAIN_SHIFT      = 3,
  parameter int GAIN_RESET      = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  audio_gain_mixer_if.slave       bus,
  input  logic [2:0]              gain_key_new_signal,
  output logic [6:0]              gain_hex_new_signal,
  output logic [6:0]              chan_hex
);
  localparam int IDX_W = clog2(NUM_CH);
  localparam int ACC_W = SAMPLE_W + GAIN_W + IDX_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [2:0]                 w_press;
  logic [GAIN_W-1:0]          r_gain [NUM_CH];
  logic [GAIN_W-1:0]          r_snap [NUM_CH];
  logic [IDX_W-1:0]           r_sel, r_idx;
  logic [6:0]                 r_gain_hex, r_chan_hex;
  logic [NUM_CH*SAMPLE_W-1:0] r_frame;
  logic signed [ACC_W-1:0]    r_acc;
  logic [SAMPLE_W-1:0]        r_out_data;
  state_t                     r_state, w_next;
  logic                       w_in_ready, w_out_valid;
  logic [GAIN_W-1:0]          w_gain_sel, w_gain_cur;
  logic [SAMPLE_W-1:0]        w_sample, w_sat;
  logic signed [ACC_W-1:0]    w_sample_x, w_gain_x, w_prod, w_shift;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .i_key_n (gain_key_new_signal[k]),
      .o_press (w_press[k])
    );
  end

  assign w_gain_sel = r_gain[r_sel];

  // Gain events always target the channel selected before any same-cycle channel step.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < NUM_CH; k++) r_gain[k] <= GAIN_W'(GAIN_RESET);
      r_sel      <= '0;
      r_gain_hex <= seg7(4'(GAIN_RESET));
      r_chan_hex <= seg7(4'd0);
    end else begin
      if (w_press[KEY_UP] && !w_press[KEY_DN] && w_gain_sel != '1)
        r_gain[r_sel] <= w_gain_sel + 1'b1;
      else if (w_press[KEY_DN] && !w_press[KEY_UP] && w_gain_sel != '0)
        r_gain[r_sel] <= w_gain_sel - 1'b1;
      if (w_press[KEY_CH])
        r_sel <= (r_sel == IDX_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
      r_gain_hex <= seg7(4'(w_gain_sel));
      r_chan_hex <= seg7(4'(r_sel));
    end
  end

  assign w_sample   = r_frame[r_idx*SAMPLE_W +: SAMPLE_W];
  assign w_gain_cur = r_snap[r_idx];
  assign w_sample_x = {{(ACC_W-SAMPLE_W){w_sample[SAMPLE_W-1]}}, w_sample};
  assign w_gain_x   = {{(ACC_W-GAIN_W){1'b0}}, w_gain_cur};
  assign w_prod     = w_sample_x * w_gain_x;
  assign w_shift    = r_acc >>> GAIN_SHIFT;

  always_comb begin
    w_sat = w_shift[SAMPLE_W-1:0];
    if (w_shift > SAT_MAX)      w_sat = SAT_MAX[SAMPLE_W-1:0];
    else if (w_shift < SAT_MIN) w_sat = SAT_MIN[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_ACCUM;
      end
      ST_ACCUM: if (r_idx == IDX_W'(NUM_CH - 1)) w_next = ST_SAT;
      ST_SAT:   w_next = ST_OUT;
      ST_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Gains are snapshotted at accept so key activity never disturbs a frame in flight.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_frame    <= '0;
      for (int k = 0; k < NUM_CH; k++) r_snap[k] <= GAIN_W'(GAIN_RESET);
      r_acc      <= '0;
      r_idx      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_frame <= bus.in_data;
          r_snap  <= r_gain;
          r_acc   <= '0;
          r_idx   <= '0;
        end
        ST_ACCUM: begin
          r_acc <= r_acc + w_prod;
          r_idx <= r_idx + 1'b1;
        end
        ST_SAT:  r_out_data <= w_sat;
        default: ;
      endcase
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = w_out_valid;
  assign bus.out_data        = r_out_data;
  assign gain_hex_new_signal = r_gain_hex;
  assign chan_hex            = r_chan_hex;
endmodule

// File: tb/tb_audio_gain_mixer.sv
// tb/tb_audio_gain_mixer.sv - directed self-checking bench for audio_gain_mixer
module tb_audio_gain_mixer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] keys;
  wire  [6:0] gain_hex;
  wire  [6:0] chan_hex;
  int         n_tests = 0;
  int         n_fail  = 0;

  audio_gain_mixer_if #(.NUM_CH(4), .SAMPLE_W(24)) bus ();

  audio_gain_mixer #(
    .NUM_CH(4), .SAMPLE_W(24), .GAIN_W(4), .GAIN_SHIFT(3), .GAIN_RESET(8), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_clk             (clk),
    .reset_reset_n       (rst_n),
    .bus                 (bus),
    .gain_key_new_signal (keys),
    .gain_hex_new_signal (gain_hex),
    .chan_hex            (chan_hex)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] mk(input int a, input int b, input int c, input int d);
    return {d[23:0], c[23:0], b[23:0], a[23:0]};
  endfunction

  task automatic drive_frame(input logic [95:0] d);
    int t;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_frame(input string tag, input logic [95:0] d, input logic [23:0] exp);
    int lat;
    drive_frame(d);
    wait_out(lat);
    check({tag, " latency"}, lat, 6);
    check({tag, " data"}, bus.out_data, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input int k);
    @(negedge clk);
    keys[k] = 1'b0;
    repeat (10) @(negedge clk);
    keys[k] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n        = 1'b0;
    keys         = 3'b111;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_data", bus.out_data, 0);
    check("reset gain_hex", gain_hex, 7'h00);
    check("reset chan_hex", chan_hex, 7'h40);

    run_frame("mix_basic", mk(100, 200, -50, 0), 24'd250);
    run_frame("clamp_pos", mk(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF), 24'h7FFFFF);
    run_frame("clamp_neg", mk(-8388608, -8388608, -8388608, -8388608), 24'h800000);

    repeat (10) press(0);
    check("gain up sat hex", gain_hex, 7'h0E);
    repeat (20) press(1);
    check("gain dn sat hex", gain_hex, 7'h40);
    run_frame("gain_zero", mk(1000, 8, 0, 0), 24'd8);
    press(0);
    check("gain one hex", gain_hex, 7'h79);
    run_frame("floor_m1", mk(-1, 0, 0, 0), 24'hFFFFFF);
    run_frame("floor_m9", mk(-9, 0, 0, 0), 24'hFFFFFE);

    // Output stall: hold data, refuse the next frame until handshake.
    bus.out_ready = 1'b0;
    drive_frame(mk(10, 20, 30, 40));
    wait_out(lat);
    check("stall latency", lat, 6);
    bus.in_data  = mk(8, 0, 0, 0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall out_valid", bus.out_valid, 1);
      check("stall out_data", bus.out_data, 24'd91);
      check("stall in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post stall out_valid", bus.out_valid, 0);
    check("post stall in_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("second frame latency", lat, 6);
    check("second frame data", bus.out_data, 24'd1);
    @(posedge clk);
    @(negedge clk);

    @(negedge clk);
    keys[0] = 1'b0;
    repeat (2) @(negedge clk);
    keys[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch no event", gain_hex, 7'h79);

    @(negedge clk);
    keys[1:0] = 2'b00;
    repeat (10) @(negedge clk);
    keys = 3'b111;
    repeat (10) @(negedge clk);
    check("up+down no change", gain_hex, 7'h79);

    press(2);
    check("chan step hex", chan_hex, 7'h79);
    check("chan1 gain hex", gain_hex, 7'h00);
    repeat (3) press(2);
    check("chan wrap hex", chan_hex, 7'h40);
    check("chan0 gain hex", gain_hex, 7'h79);

    // Gain change lands while the frame is accumulating.
    repeat (2) press(2);
    check("chan2 hex", chan_hex, 7'h24);
    @(negedge clk);
    keys[0] = 1'b0;
    repeat (4) @(negedge clk);
    drive_frame(mk(0, 0, 800, 0));
    wait_out(lat);
    check("snapshot latency", lat, 6);
    check("snapshot old gain", bus.out_data, 24'd800);
    @(posedge clk);
    @(negedge clk);
    keys[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("chan2 gain9 hex", gain_hex, 7'h10);
    run_frame("new_gain", mk(0, 0, 800, 0), 24'd900);

    drive_frame(mk(0, 0, 800, 0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    check("reset drops frame", seen, 0);
    check("reset mid in_ready", bus.in_ready, 1);
    check("reset mid gain_hex", gain_hex, 7'h00);
    check("reset mid chan_hex", chan_hex, 7'h40);
    repeat (2) press(2);
    check("chan2 gain reset hex", gain_hex, 7'h00);
    run_frame("after_reset", mk(0, 0, 800, 0), 24'd800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
